// File: rtl/voice_alloc.sv
// voice_alloc: four-voice note allocator in front of four ADSR envelopes.
// Each voice is held (gate high), free (gate low and envelope idle) or releasing.
// A note-on goes to the lowest-index free voice. When every voice is held, the
// oldest held voice is stolen, and the note-on waits until that voice is free.
module voice_alloc #(
    parameter int NOTE_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ev_valid,
    input  logic                ev_on,
    input  logic [NOTE_W-1:0]   ev_note,
    output logic                ev_ready,
    input  logic [3:0]          voice_idle,
    output logic [3:0]          trig,
    output logic [4*NOTE_W-1:0] voice_note,
    output logic                steal
);
    localparam int NV = 4;

    logic [NV-1:0]              trig_q, trig_d;
    logic [NV-1:0][NOTE_W-1:0]  note_q, note_d;
    logic [NV-1:0][1:0]         age_q, age_d;
    logic                       steal_q, steal_d;

    logic [NV-1:0] held, free_v, rel_v, note_hit;
    logic          any_hit, any_free, any_rel;
    logic [1:0]    free_idx, old_idx;
    logic [1:0]    old_age;
    logic          old_found;
    logic          accept;

    // Voice classification is derived from the gate and envelope flags every cycle, with no stored state.
    // The same block finds the lowest free voice and the oldest held voice.
    always_comb begin
        held      = trig_q;
        free_v    = ~trig_q & voice_idle;
        rel_v     = ~trig_q & ~voice_idle;
        note_hit  = '0;
        free_idx  = 2'd0;
        old_idx   = 2'd0;
        old_age   = 2'd0;
        old_found = 1'b0;
        for (int i = 0; i < NV; i++) begin
            note_hit[i] = trig_q[i] && (note_q[i] == ev_note);
        end
        for (int i = NV - 1; i >= 0; i--) begin
            if (free_v[i]) free_idx = 2'(i);
        end
        // A strict compare means that, among voices with equal age, the lowest index wins.
        for (int i = 0; i < NV; i++) begin
            if (held[i] && (!old_found || age_q[i] > old_age)) begin
                old_found = 1'b1;
                old_age   = age_q[i];
                old_idx   = 2'(i);
            end
        end
        any_hit  = |note_hit;
        any_free = |free_v;
        any_rel  = |rel_v;
    end

    // Acceptance. A note-off is always taken. A note-on is taken when it is already sounding or when a voice is free.
    assign ev_ready = !rst && (!ev_on || any_hit || any_free);
    assign accept   = ev_valid && ev_ready;

    // Next-state logic covers allocation, release and stealing.
    // A steal happens only when a note-on is blocked and nothing is already releasing.
    always_comb begin
        trig_d  = trig_q;
        note_d  = note_q;
        age_d   = age_q;
        steal_d = 1'b0;
        if (accept) begin
            if (!ev_on) begin
                trig_d = trig_q & ~note_hit;
            end else if (!any_hit) begin
                for (int i = 0; i < NV; i++) begin
                    if (held[i] && age_q[i] != 2'd3) age_d[i] = age_q[i] + 2'd1;
                end
                trig_d[free_idx] = 1'b1;
                note_d[free_idx] = ev_note;
                age_d[free_idx]  = 2'd0;
            end
        end else if (ev_valid && ev_on && !rst && !any_rel && old_found) begin
            trig_d[old_idx] = 1'b0;
            steal_d         = 1'b1;
        end
    end

    // State registers. Reset drops every gate at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q  <= '0;
            note_q  <= '0;
            age_q   <= '0;
            steal_q <= 1'b0;
        end else begin
            trig_q  <= trig_d;
            note_q  <= note_d;
            age_q   <= age_d;
            steal_q <= steal_d;
        end
    end

    assign trig       = trig_q;
    assign voice_note = note_q;
    assign steal      = steal_q;

endmodule
